// File: rtl/ysyx_mem_pkg.sv
// ysyx_mem_pkg: types and constants shared by the LSU request side
// and the data-memory responder.
package ysyx_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } mem_state_t;

    localparam logic [31:0] MEM_BASE_DEF = 32'h8000_0000;
    localparam int          CNT_W        = 4;

    // Widened to 33 bits so base + span cannot wrap past 2^32.
    function automatic logic addr_in_range(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [32:0] span
    );
        logic [32:0] a;
        logic [32:0] b;
        a = {1'b0, addr};
        b = {1'b0, base};
        return (a >= b) && (a < b + span);
    endfunction

endpackage

// File: rtl/ysyx_sram_array.sv
// ysyx_sram_array: word array with per-byte synchronous write and
// combinational read.
module ysyx_sram_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    wmask,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ysyx_dmem_responder.sv
// ysyx_dmem_responder: single-outstanding data-memory target for the
// EXU/LSU path with a fixed response latency.
module ysyx_dmem_responder
    import ysyx_mem_pkg::*;
#(
    parameter logic [31:0] MEM_BASE    = MEM_BASE_DEF,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wmask,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
    localparam logic [CNT_W-1:0] CNT_INIT =
        CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

    mem_state_t     state;
    logic [CNT_W-1:0] cnt;
    logic           r_wen;
    logic           r_ok;
    logic [AW-1:0]  r_idx;

    logic           accept;
    logic           req_ok;
    logic [AW-1:0]  req_idx;
    logic [AW-1:0]  rd_idx;
    logic           ld_wen;
    logic           ld_ok;
    logic [31:0]    arr_rdata;
    logic [31:0]    ld_data;

    assign accept  = (state == IDLE) && req_valid;
    assign req_ok  = addr_in_range(req_addr, MEM_BASE, SPAN);
    assign req_idx = AW'((req_addr - MEM_BASE) >> 2);

    // With LATENCY==1 the response loads on the accept edge itself,
    // before the captured request registers are valid.
    assign rd_idx  = (state == IDLE) ? req_idx : r_idx;
    assign ld_wen  = (state == IDLE) ? req_wen : r_wen;
    assign ld_ok   = (state == IDLE) ? req_ok  : r_ok;
    assign ld_data = (ld_wen || !ld_ok) ? 32'd0 : arr_rdata;

    ysyx_sram_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk  (clk),
        .we   (accept && req_wen && req_ok),
        .wmask(req_wmask),
        .waddr(req_idx),
        .wdata(req_wdata),
        .raddr(rd_idx),
        .rdata(arr_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            r_wen      <= 1'b0;
            r_ok       <= 1'b0;
            r_idx      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        r_wen     <= req_wen;
                        r_ok      <= req_ok;
                        r_idx     <= req_idx;
                        req_ready <= 1'b0;
                        if (LATENCY == 1) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= ld_data;
                            resp_err   <= !ld_ok;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= ld_data;
                        resp_err   <= !ld_ok;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        req_ready  <= 1'b1;
                        resp_valid <= 1'b0;
                        resp_rdata <= 32'd0;
                        resp_err   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_dmem_responder.sv
// tb_ysyx_dmem_responder: directed checks of the responder at
// latencies 1, 3 and 4.
module tb_ysyx_dmem_responder;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        resp_ready;
    int          sel;

    logic [2:0]        rr;
    logic [2:0]        rv;
    logic [2:0]        re;
    logic [2:0][31:0]  rd;

    logic        rr_s;
    logic        rv_s;
    logic        re_s;
    logic [31:0] rd_s;

    int checks   = 0;
    int failures = 0;

    ysyx_dmem_responder #(.LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid && sel == 0), .req_ready(rr[0]),
        .req_wen(req_wen), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(rv[0]), .resp_ready(resp_ready),
        .resp_rdata(rd[0]), .resp_err(re[0])
    );

    ysyx_dmem_responder #(.LATENCY(3)) dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid && sel == 1), .req_ready(rr[1]),
        .req_wen(req_wen), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(rv[1]), .resp_ready(resp_ready),
        .resp_rdata(rd[1]), .resp_err(re[1])
    );

    ysyx_dmem_responder #(.LATENCY(4)) dut4 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid && sel == 2), .req_ready(rr[2]),
        .req_wen(req_wen), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(rv[2]), .resp_ready(resp_ready),
        .resp_rdata(rd[2]), .resp_err(re[2])
    );

    always_comb begin
        rr_s = rr[sel];
        rv_s = rv[sel];
        re_s = re[sel];
        rd_s = rd[sel];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] m);
        int n = 0;
        req_valid = 1'b1;
        req_wen   = w;
        req_addr  = a;
        req_wdata = d;
        req_wmask = m;
        while (!rr_s && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_wait", 32'(rr_s), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic get_resp(input string tag, input logic [31:0] exp_d,
                            input logic exp_e);
        int n = 0;
        resp_ready = 1'b1;
        while (!rv_s && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("%s_valid", tag), 32'(rv_s), 32'd1);
        chk($sformatf("%s_rdata", tag), rd_s, exp_d);
        chk($sformatf("%s_err", tag), 32'(re_s), 32'(exp_e));
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_wen    = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_wmask  = 4'd0;
        resp_ready = 1'b0;
        sel        = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(rr), 32'h7);
        chk("rst_resp_valid", 32'(rv), 32'h0);
        chk("rst_resp_err", 32'(re), 32'h0);
        chk("rst_rdata0", rd[0], 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // LATENCY=1: masked write, misalignment, range
        do_req(1'b1, 32'h8000_0010, 32'h1122_3344, 4'hF);
        get_resp("wr_pre", 32'h0, 1'b0);
        do_req(1'b1, 32'h8000_0010, 32'hAABB_CCDD, 4'b0011);
        get_resp("wr_mask", 32'h0, 1'b0);
        do_req(1'b0, 32'h8000_0010, 32'h0, 4'h0);
        get_resp("rd_mask", 32'h1122_CCDD, 1'b0);

        do_req(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
        get_resp("wr_mis", 32'h0, 1'b0);
        do_req(1'b0, 32'h8000_0013, 32'h0, 4'h0);
        get_resp("rd_mis", 32'hDEAD_BEEF, 1'b0);

        do_req(1'b1, 32'h8000_0000, 32'h0BAD_F00D, 4'hF);
        get_resp("wr_w0", 32'h0, 1'b0);
        do_req(1'b1, 32'h8000_0FFC, 32'h5A5A_0001, 4'hF);
        get_resp("wr_top", 32'h0, 1'b0);
        do_req(1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0);
        get_resp("rd_low", 32'h0, 1'b1);
        do_req(1'b1, 32'h8000_1000, 32'hFFFF_FFFF, 4'hF);
        get_resp("wr_high", 32'h0, 1'b1);
        do_req(1'b1, 32'h7FFF_FFFC, 32'h0, 4'hF);
        get_resp("wr_low", 32'h0, 1'b1);
        do_req(1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0);
        get_resp("rd_wrap", 32'h0, 1'b1);
        do_req(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 4'h0);
        get_resp("wr_nomask", 32'h0, 1'b0);
        do_req(1'b0, 32'h8000_0000, 32'h0, 4'h0);
        get_resp("rd_w0", 32'h0BAD_F00D, 1'b0);
        do_req(1'b0, 32'h8000_0FFC, 32'h0, 4'h0);
        get_resp("rd_top", 32'h5A5A_0001, 1'b0);

        // LATENCY=3: timing and backpressure
        sel = 1;
        @(negedge clk);
        do_req(1'b1, 32'h8000_0040, 32'h1357_9BDF, 4'hF);
        get_resp("l3_wr", 32'h0, 1'b0);
        req_valid = 1'b1;
        req_wen   = 1'b0;
        req_addr  = 32'h8000_0040;
        chk("l3_ready_pre", 32'(rr_s), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("l3_e1_ready", 32'(rr_s), 32'd0);
        chk("l3_e1_valid", 32'(rv_s), 32'd0);
        @(negedge clk);
        chk("l3_e2_ready", 32'(rr_s), 32'd0);
        chk("l3_e2_valid", 32'(rv_s), 32'd0);
        @(negedge clk);
        chk("l3_e3_ready", 32'(rr_s), 32'd0);
        chk("l3_e3_valid", 32'(rv_s), 32'd1);
        req_valid = 1'b1;
        req_wen   = 1'b1;
        req_addr  = 32'h8000_0044;
        req_wdata = 32'h2468_ACE0;
        req_wmask = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(rv_s), 32'd1);
            chk("bp_rdata", rd_s, 32'h1357_9BDF);
            chk("bp_err", 32'(re_s), 32'd0);
            chk("bp_ready", 32'(rr_s), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        chk("bp_hs_valid", 32'(rv_s), 32'd0);
        chk("bp_hs_ready", 32'(rr_s), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("bp2_accepted", 32'(rr_s), 32'd0);
        get_resp("bp2_wr", 32'h0, 1'b0);
        do_req(1'b0, 32'h8000_0044, 32'h0, 4'h0);
        get_resp("bp2_rd", 32'h2468_ACE0, 1'b0);

        // LATENCY=4: reset while waiting
        sel = 2;
        @(negedge clk);
        do_req(1'b1, 32'h8000_0020, 32'hCAFE_F00D, 4'hF);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("l4_wait_ready", 32'(rr_s), 32'd0);
        rst = 1'b1;
        #1;
        chk("l4_rst_valid", 32'(rv_s), 32'd0);
        chk("l4_rst_ready", 32'(rr_s), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("l4_dropped", 32'(rv_s), 32'd0);
        do_req(1'b0, 32'h8000_0020, 32'h0, 4'h0);
        get_resp("l4_rd", 32'hCAFE_F00D, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
